// File: rtl/pinwheel_uart_pkg.sv
// Register map, serializer states and STATUS layout for the pinwheel transmit UART.
package pinwheel_uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  localparam int STAT_COUNT_LSB = 0;
  localparam int STAT_EMPTY     = 6;
  localparam int STAT_FULL      = 7;
  localparam int STAT_BUSY      = 8;
  localparam int STAT_OVERFLOW  = 9;

  // A divisor of zero would never let a bit period end, so it runs as one.
  function automatic logic [15:0] clamp_div(input logic [15:0] div);
    return (div == 16'd0) ? 16'd1 : div;
  endfunction

endpackage

// File: rtl/tilelink_pkg.sv
// TileLink-UL channel types and opcodes shared by the pinwheel data-bus peripherals.
package tilelink_pkg;

  // A-channel opcodes
  localparam logic [2:0] PUT_FULL_DATA    = 3'd0;
  localparam logic [2:0] PUT_PARTIAL_DATA = 3'd1;
  localparam logic [2:0] ARITHMETIC_DATA  = 3'd2;
  localparam logic [2:0] LOGICAL_DATA     = 3'd3;
  localparam logic [2:0] GET              = 3'd4;

  // D-channel opcodes
  localparam logic [2:0] ACCESS_ACK      = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [2:0]  a_size;
    logic [3:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
  } tilelink_a;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [2:0]  d_size;
    logic [3:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        d_ready;
  } tilelink_d;

endpackage

// File: rtl/pinwheel_sync_fifo.sv
// Single-clock FIFO; the caller guarantees push only when there is room (or a pop in the same cycle).
module pinwheel_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: storage is deliberately left out of reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == FULL_COUNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/pinwheel_uart_tx.sv
// Transmit-only 8N1 UART on the pinwheel data bus: TileLink A in, registered D out, byte FIFO feeding a serializer.
module pinwheel_uart_tx
  import tilelink_pkg::*;
  import pinwheel_uart_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd434,
  parameter logic [3:0]  BUS_TAG     = 4'h4
) (
  input  logic      clock,
  input  logic      tick_reset_n,
  input  tilelink_a tock_tla,
  output tilelink_d tld,
  output logic      tx,
  output logic      busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic            sel, is_write, push_req, clr_req;
  logic [1:0]      reg_idx;
  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]      fifo_rdata;
  logic [CW-1:0]   fifo_count;
  logic [15:0]     div_q, div_d, div_eff;
  logic            overflow_q, overflow_d;
  logic [31:0]     rdata;
  tilelink_d       tld_q, tld_d;
  tx_state_t       state_q;
  logic            tx_q;
  logic [7:0]      shift_q;
  logic [15:0]     div_l_q, bitcnt_q;
  logic [2:0]      bitidx_q;
  logic            unused_a;

  assign sel      = tock_tla.a_valid && (tock_tla.a_address[31:28] == BUS_TAG);
  assign is_write = (tock_tla.a_opcode == PUT_FULL_DATA) || (tock_tla.a_opcode == PUT_PARTIAL_DATA);
  assign reg_idx  = tock_tla.a_address[3:2];
  assign push_req = sel && is_write && (reg_idx == REG_DATA) && tock_tla.a_mask[0];
  assign clr_req  = sel && is_write && (reg_idx == REG_STATUS) && tock_tla.a_mask[0];

  // A full FIFO still takes the byte when the serializer drains one in the same cycle.
  assign fifo_pop  = (state_q == TX_IDLE) && !fifo_empty;
  assign fifo_push = push_req && (!fifo_full || fifo_pop);
  assign busy      = (state_q != TX_IDLE) || !fifo_empty;
  assign div_eff   = clamp_div(div_q);

  assign unused_a = ^{tock_tla.a_param, tock_tla.a_source, tock_tla.a_address[27:4],
                      tock_tla.a_address[1:0], tock_tla.a_mask[3:2], tock_tla.a_data[31:16]};

  pinwheel_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clock),
    .rst_n  (tick_reset_n),
    .push_i (fifo_push),
    .wdata_i(tock_tla.a_data[7:0]),
    .pop_i  (fifo_pop),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    rdata      = '0;
    div_d      = div_q;
    overflow_d = overflow_q;
    tld_d      = '0;

    case (reg_idx)
      REG_STATUS: begin
        rdata[STAT_COUNT_LSB +: 6] = 6'(fifo_count);
        rdata[STAT_EMPTY]          = fifo_empty;
        rdata[STAT_FULL]           = fifo_full;
        rdata[STAT_BUSY]           = busy;
        rdata[STAT_OVERFLOW]       = overflow_q;
      end
      REG_DIV: rdata[15:0] = div_q;
      default: ;
    endcase

    if (sel && is_write && (reg_idx == REG_DIV)) begin
      if (tock_tla.a_mask[0]) div_d[7:0]  = tock_tla.a_data[7:0];
      if (tock_tla.a_mask[1]) div_d[15:8] = tock_tla.a_data[15:8];
    end

    // A dropped byte outranks a clear arriving in the same cycle.
    if (clr_req) overflow_d = 1'b0;
    if (push_req && !fifo_push) overflow_d = 1'b1;

    tld_d.d_ready = 1'b1;
    if (sel) begin
      tld_d.d_valid  = 1'b1;
      tld_d.d_opcode = is_write ? ACCESS_ACK : ACCESS_ACK_DATA;
      tld_d.d_size   = tock_tla.a_size;
      tld_d.d_data   = rdata;
    end
  end

  always_ff @(posedge clock) begin
    if (!tick_reset_n) begin
      div_q      <= DEFAULT_DIV;
      overflow_q <= 1'b0;
      tld_q      <= '0;
    end else begin
      div_q      <= div_d;
      overflow_q <= overflow_d;
      tld_q      <= tld_d;
    end
  end

  // Serializer: div_l is latched at pop so DIVISOR writes only affect the next frame.
  always_ff @(posedge clock) begin
    if (!tick_reset_n) begin
      state_q  <= TX_IDLE;
      tx_q     <= 1'b1;
      shift_q  <= '0;
      div_l_q  <= 16'd1;
      bitcnt_q <= '0;
      bitidx_q <= '0;
    end else begin
      case (state_q)
        TX_IDLE: begin
          if (fifo_pop) begin
            shift_q  <= fifo_rdata;
            div_l_q  <= div_eff;
            bitcnt_q <= div_eff - 16'd1;
            tx_q     <= 1'b0;
            state_q  <= TX_START;
          end
        end
        TX_START: begin
          if (bitcnt_q == 16'd0) begin
            bitcnt_q <= div_l_q - 16'd1;
            bitidx_q <= '0;
            tx_q     <= shift_q[0];
            state_q  <= TX_DATA;
          end else begin
            bitcnt_q <= bitcnt_q - 16'd1;
          end
        end
        TX_DATA: begin
          if (bitcnt_q == 16'd0) begin
            bitcnt_q <= div_l_q - 16'd1;
            if (bitidx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= TX_STOP;
            end else begin
              shift_q  <= shift_q >> 1;
              tx_q     <= shift_q[1];
              bitidx_q <= bitidx_q + 3'd1;
            end
          end else begin
            bitcnt_q <= bitcnt_q - 16'd1;
          end
        end
        TX_STOP: begin
          if (bitcnt_q == 16'd0) state_q <= TX_IDLE;
          else                   bitcnt_q <= bitcnt_q - 16'd1;
        end
        default: state_q <= TX_IDLE;
      endcase
    end
  end

  assign tx  = tx_q;
  assign tld = tld_q;

endmodule

// File: tb/tb_pinwheel_uart_tx.sv
// Directed bench for pinwheel_uart_tx: register-access vector table plus frame, overflow and reset sequences.
module tb_pinwheel_uart_tx;
  import tilelink_pkg::*;

  localparam logic [31:0] A_DATA   = 32'h4000_0000;
  localparam logic [31:0] A_STATUS = 32'h4000_0004;
  localparam logic [31:0] A_DIV    = 32'h4000_0008;

  logic      clock = 1'b0;
  logic      tick_reset_n;
  tilelink_a tla;
  tilelink_d tld;
  logic      tx, busy;
  int        tests = 0;
  int        fails = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
    logic [2:0]  size;
    logic        exp_valid;
    logic [2:0]  exp_op;
    logic        chk_data;
    logic [31:0] exp_data;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] q_bytes[18];

  pinwheel_uart_tx dut (
    .clock       (clock),
    .tick_reset_n(tick_reset_n),
    .tock_tla    (tla),
    .tld         (tld),
    .tx          (tx),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time exceeded, limit 2000000");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One bus request held for exactly one cycle; on return tld holds its response.
  task automatic req(input logic [2:0] op, input logic [31:0] addr, input logic [3:0] mask,
                     input logic [31:0] data, input logic [2:0] size);
    tla           = '0;
    tla.a_valid   = 1'b1;
    tla.a_opcode  = op;
    tla.a_address = addr;
    tla.a_mask    = mask;
    tla.a_data    = data;
    tla.a_size    = size;
    step();
    tla.a_valid   = 1'b0;
  endtask

  task automatic wait_tx(input logic lvl, input int budget, input string name);
    int n = 0;
    while (tx !== lvl && n < budget) begin
      step();
      n++;
    end
    check(name, 32'(tx), 32'(lvl));
  endtask

  // Called in the first START cycle; samples the whole 10-bit frame, ending in the following cycle.
  task automatic check_frame(input logic [7:0] b, input int div, input string name);
    int   errs = 0;
    int   bitno;
    logic exp;
    for (int i = 0; i < 10 * div; i++) begin
      bitno = i / div;
      if (bitno == 0)      exp = 1'b0;
      else if (bitno == 9) exp = 1'b1;
      else                 exp = b[bitno-1];
      if (tx !== exp) errs++;
      step();
    end
    check(name, 32'(errs), 32'd0);
  endtask

  initial begin
    tla          = '0;
    tick_reset_n = 1'b0;

    // Reset with a live request on the bus: the response register must stay clear.
    tla.a_valid   = 1'b1;
    tla.a_opcode  = GET;
    tla.a_address = A_DIV;
    tla.a_size    = 3'd2;
    step();
    step();
    check("reset_tld_zero", 32'(tld == '0), 32'd1);
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    tla.a_valid  = 1'b0;
    tick_reset_n = 1'b1;

    vecs.push_back('{GET,              32'h4000_0008, 4'hF, 32'h0,         3'd2, 1'b1, ACCESS_ACK_DATA, 1'b1, 32'h1B2});
    vecs.push_back('{GET,              32'h4000_0004, 4'hF, 32'h0,         3'd2, 1'b1, ACCESS_ACK_DATA, 1'b1, 32'h40});
    vecs.push_back('{GET,              32'h4000_0000, 4'hF, 32'h0,         3'd2, 1'b1, ACCESS_ACK_DATA, 1'b1, 32'h0});
    vecs.push_back('{GET,              32'h4000_000C, 4'hF, 32'h0,         3'd2, 1'b1, ACCESS_ACK_DATA, 1'b1, 32'h0});
    vecs.push_back('{GET,              32'h0000_0008, 4'hF, 32'h0,         3'd2, 1'b0, ACCESS_ACK,      1'b1, 32'h0});
    vecs.push_back('{PUT_FULL_DATA,    32'h4000_0008, 4'hF, 32'h1234,      3'd2, 1'b1, ACCESS_ACK,      1'b0, 32'h0});
    vecs.push_back('{GET,              32'h4000_0008, 4'hF, 32'h0,         3'd2, 1'b1, ACCESS_ACK_DATA, 1'b1, 32'h1234});
    vecs.push_back('{PUT_PARTIAL_DATA, 32'h4000_0008, 4'h1, 32'hFFFF_FFAB, 3'd0, 1'b1, ACCESS_ACK,      1'b0, 32'h0});
    vecs.push_back('{GET,              32'h4000_0008, 4'hF, 32'h0,         3'd2, 1'b1, ACCESS_ACK_DATA, 1'b1, 32'h12AB});
    vecs.push_back('{PUT_PARTIAL_DATA, 32'h4000_0008, 4'h2, 32'h0000_CD00, 3'd1, 1'b1, ACCESS_ACK,      1'b0, 32'h0});
    vecs.push_back('{GET,              32'h4ABC_DE08, 4'hF, 32'h0,         3'd1, 1'b1, ACCESS_ACK_DATA, 1'b1, 32'hCDAB});
    vecs.push_back('{PUT_FULL_DATA,    32'h4000_000C, 4'hF, 32'hFFFF_FFFF, 3'd2, 1'b1, ACCESS_ACK,      1'b0, 32'h0});
    vecs.push_back('{GET,              32'h4000_000C, 4'hF, 32'h0,         3'd2, 1'b1, ACCESS_ACK_DATA, 1'b1, 32'h0});
    vecs.push_back('{PUT_PARTIAL_DATA, 32'h4000_0004, 4'h0, 32'h0,         3'd2, 1'b1, ACCESS_ACK,      1'b0, 32'h0});
    vecs.push_back('{ARITHMETIC_DATA,  32'h4000_0000, 4'h1, 32'h77,        3'd2, 1'b1, ACCESS_ACK_DATA, 1'b1, 32'h0});
    vecs.push_back('{GET,              32'h4000_0004, 4'hF, 32'h0,         3'd2, 1'b1, ACCESS_ACK_DATA, 1'b1, 32'h40});
    vecs.push_back('{GET,              32'h5000_0004, 4'hF, 32'h0,         3'd2, 1'b0, ACCESS_ACK,      1'b1, 32'h0});
    vecs.push_back('{PUT_FULL_DATA,    32'h3000_0000, 4'h1, 32'h11,        3'd2, 1'b0, ACCESS_ACK,      1'b1, 32'h0});
    vecs.push_back('{GET,              32'h4000_0004, 4'hF, 32'h0,         3'd2, 1'b1, ACCESS_ACK_DATA, 1'b1, 32'h40});

    foreach (vecs[i]) begin
      req(vecs[i].op, vecs[i].addr, vecs[i].mask, vecs[i].data, vecs[i].size);
      check($sformatf("v%0d_d_valid", i), 32'(tld.d_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        check($sformatf("v%0d_d_opcode", i), 32'(tld.d_opcode), 32'(vecs[i].exp_op));
        check($sformatf("v%0d_d_size", i), 32'(tld.d_size), 32'(vecs[i].size));
      end
      if (vecs[i].chk_data) check($sformatf("v%0d_d_data", i), tld.d_data, vecs[i].exp_data);
    end

    req(GET, A_DIV, 4'hF, 32'h0, 3'd2);
    check("d_misc", {23'b0, tld.d_param, tld.d_source, tld.d_sink, tld.d_error, tld.d_ready}, 32'h1);

    // The core reads every cycle it is not storing; reads must never pop or start a frame.
    for (int i = 0; i < 20; i++) begin
      req(GET, (i % 2 == 1) ? A_STATUS : A_DATA, 4'hF, 32'h0, 3'd2);
      check($sformatf("idle_get_%0d", i), tld.d_data, (i % 2 == 1) ? 32'h40 : 32'h0);
    end
    check("idle_get_tx", 32'(tx), 32'd1);
    check("idle_get_busy", 32'(busy), 32'd0);

    // 0x55 at DIVISOR = 4, including the push-to-start-bit latency.
    req(PUT_FULL_DATA, A_DIV, 4'hF, 32'd4, 3'd2);
    req(PUT_PARTIAL_DATA, A_DATA, 4'h1, 32'h55, 3'd0);
    check("tx_before_start", 32'(tx), 32'd1);
    check("busy_queued", 32'(busy), 32'd1);
    step();
    check("tx_start_latency", 32'(tx), 32'd0);
    check_frame(8'h55, 4, "frame_55_div4");
    check("busy_after_stop", 32'(busy), 32'd0);
    check("tx_after_stop", 32'(tx), 32'd1);

    // DIVISOR = 0 runs as one clock per bit; the register still reads back 0.
    req(PUT_PARTIAL_DATA, A_DIV, 4'h3, 32'h0, 3'd1);
    req(GET, A_DIV, 4'hF, 32'h0, 3'd2);
    check("div0_readback", tld.d_data, 32'h0);
    req(PUT_PARTIAL_DATA, A_DATA, 4'h1, 32'h00, 3'd0);
    wait_tx(1'b0, 4, "div0_start");
    check_frame(8'h00, 1, "frame_00_div1");
    check("div0_busy_after", 32'(busy), 32'd0);

    // Fill to full at DIVISOR = 2. Byte 0 leaves the FIFO the cycle after it lands, so 17 stores
    // fill it; the next pop is 22 cycles after the first push and coincides with store 17.
    for (int k = 0; k < 18; k++) q_bytes[k] = 8'(k * 37 + 3);
    q_bytes[1] = 8'h00;
    req(PUT_FULL_DATA, A_DIV, 4'hF, 32'd2, 3'd2);
    for (int k = 0; k < 17; k++) req(PUT_PARTIAL_DATA, A_DATA, 4'h1, {24'hFFFFFF, q_bytes[k]}, 3'd0);
    repeat (5) step();
    req(PUT_PARTIAL_DATA, A_DATA, 4'h1, {24'h0, q_bytes[17]}, 3'd0);
    req(GET, A_STATUS, 4'hF, 32'h0, 3'd2);
    check("status_full_push_pop", tld.d_data, 32'h190);
    req(PUT_PARTIAL_DATA, A_DATA, 4'h1, 32'hEE, 3'd0);
    req(GET, A_STATUS, 4'hF, 32'h0, 3'd2);
    check("status_overflow", tld.d_data, 32'h390);
    req(PUT_PARTIAL_DATA, A_STATUS, 4'h1, 32'h0, 3'd0);
    req(GET, A_STATUS, 4'hF, 32'h0, 3'd2);
    check("status_ovf_cleared", tld.d_data, 32'h190);

    wait_tx(1'b1, 100, "frame1_stop");
    for (int k = 2; k < 18; k++) begin
      wait_tx(1'b0, 100, $sformatf("start_%0d", k));
      check_frame(q_bytes[k], 2, $sformatf("frame_%0d", k));
    end
    check("drain_busy", 32'(busy), 32'd0);
    begin
      int bad = 0;
      for (int i = 0; i < 60; i++) begin
        if (tx !== 1'b1) bad++;
        step();
      end
      check("no_dropped_frame", 32'(bad), 32'd0);
    end
    req(GET, A_STATUS, 4'hF, 32'h0, 3'd2);
    check("status_drained", tld.d_data, 32'h40);

    // Reset in the middle of a data bit with three bytes still queued.
    req(PUT_FULL_DATA, A_DIV, 4'hF, 32'd8, 3'd2);
    for (int k = 0; k < 4; k++) req(PUT_PARTIAL_DATA, A_DATA, 4'h1, 32'h00, 3'd0);
    repeat (10) step();
    check("pre_reset_tx_low", 32'(tx), 32'd0);
    tla           = '0;
    tla.a_valid   = 1'b1;
    tla.a_opcode  = GET;
    tla.a_address = A_STATUS;
    tick_reset_n  = 1'b0;
    step();
    tick_reset_n  = 1'b1;
    tla.a_valid   = 1'b0;
    check("midframe_reset_tld", 32'(tld == '0), 32'd1);
    check("midframe_reset_tx", 32'(tx), 32'd1);
    check("midframe_reset_busy", 32'(busy), 32'd0);
    req(GET, A_STATUS, 4'hF, 32'h0, 3'd2);
    check("midframe_reset_status", tld.d_data, 32'h40);
    req(GET, A_DIV, 4'hF, 32'h0, 3'd2);
    check("midframe_reset_div", tld.d_data, 32'h1B2);
    begin
      int bad = 0;
      for (int i = 0; i < 300; i++) begin
        if (tx !== 1'b1 || busy !== 1'b0) bad++;
        step();
      end
      check("midframe_reset_quiet", 32'(bad), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
